// File: rtl/ivl_uvm_ovl_one_hot_mc.sv
`default_nettype none
// ============================================================================
// Module   : ivl_uvm_ovl_one_hot_mc
// Purpose  : Multi-channel one-hot / zero-one-hot checker. Each channel
//            fires once per run of FIRE_THRESH consecutive violating samples.
//            It also keeps saturating per-channel fire counters and captures
//            the first failure.
// Options  : IVL_UVM_OVL_XCHECK_EN - enables X/Z detection and fire_xz.
// Revision : 1.0 - initial release
// ============================================================================
module ivl_uvm_ovl_one_hot_mc #(
    parameter int WIDTH       = 4,
    parameter int CHANNELS    = 1,
    parameter int MODE        = 0,
    parameter int FIRE_THRESH = 1,
    parameter int CNT_W       = 8,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [CHANNELS*WIDTH-1:0] test_expr,
    output logic [CHANNELS-1:0]       fire,
    output logic                      fire_xz,
    output logic [CHANNELS*CNT_W-1:0] fire_count,
    output logic                      first_valid,
    output logic [CH_W-1:0]           first_chan,
    output logic [WIDTH-1:0]          first_value
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_STREAK = 2'd2,
        S_FIRED  = 2'd3
    } state_t;

    // Streak counter is wide enough for the largest legal threshold (255).
    localparam int                    STREAK_W = 8;
    localparam logic [STREAK_W-1:0]   THRESH   = STREAK_W'(FIRE_THRESH);
    localparam logic [CNT_W-1:0]      CNT_MAX  = '1;

    logic [CHANNELS-1:0] fire_nx;   // fire pulse to be registered this edge
    logic [CHANNELS-1:0] viol;      // per-channel violation of current sample
`ifdef IVL_UVM_OVL_XCHECK_EN
    logic [CHANNELS-1:0] xz_vec;    // per-channel X/Z presence
`endif

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_ch
            logic [WIDTH-1:0]    slice;
            logic                none_set;
            logic                multi_set;
            logic                rule_viol;
            state_t              state;
            state_t              state_nx;
            logic [STREAK_W-1:0] streak;
            logic [STREAK_W-1:0] streak_nx;
            logic                fire_c;
            logic [CNT_W-1:0]    cnt;

            assign slice     = test_expr[c*WIDTH +: WIDTH];
            assign none_set  = ~|slice;
            // Clearing the lowest set bit leaves something only if >1 bit set.
            assign multi_set = |(slice & (slice - WIDTH'(1)));
            assign rule_viol = (MODE == 0) ? (none_set | multi_set) : multi_set;

`ifdef IVL_UVM_OVL_XCHECK_EN
            logic has_xz;
            assign has_xz    = $isunknown(slice);
            assign xz_vec[c] = has_xz;
            // An unknown sample counts as a violation; OR with 1 masks X.
            assign viol[c]   = has_xz | rule_viol;
`else
            assign viol[c]   = rule_viol;
`endif

            // Next-state, streak and fire-pulse decode for this channel.
            always_comb begin
                state_nx  = state;
                streak_nx = streak;
                fire_c    = 1'b0;
                if (!enable) begin
                    state_nx  = S_IDLE;
                    streak_nx = '0;
                end else begin
                    case (state)
                        // IDLE with enable high arms and checks the same sample.
                        S_IDLE, S_ARMED: begin
                            if (viol[c]) begin
                                streak_nx = STREAK_W'(1);
                                if (THRESH == STREAK_W'(1)) begin
                                    state_nx = S_FIRED;
                                    fire_c   = 1'b1;
                                end else begin
                                    state_nx = S_STREAK;
                                end
                            end else begin
                                state_nx  = S_ARMED;
                                streak_nx = '0;
                            end
                        end
                        S_STREAK: begin
                            if (viol[c]) begin
                                streak_nx = streak + STREAK_W'(1);
                                if (streak_nx == THRESH) begin
                                    state_nx = S_FIRED;
                                    fire_c   = 1'b1;
                                end
                            end else begin
                                state_nx  = S_ARMED;
                                streak_nx = '0;
                            end
                        end
                        S_FIRED: begin
                            if (!viol[c]) begin
                                state_nx  = S_ARMED;
                                streak_nx = '0;
                            end
                        end
                        default: begin
                            state_nx  = S_IDLE;
                            streak_nx = '0;
                        end
                    endcase
                end
            end

            // Channel state and streak registers.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    state  <= S_IDLE;
                    streak <= '0;
                end else begin
                    state  <= state_nx;
                    streak <= streak_nx;
                end
            end

            // Saturating fire counter; clear takes priority over a fire.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (fire_c && (cnt != CNT_MAX)) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            assign fire_nx[c]                    = fire_c;
            assign fire_count[c*CNT_W +: CNT_W] = cnt;
        end
    endgenerate

    // Register the fire pulses so they are high for the cycle after the sample.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fire <= '0;
        end else begin
            fire <= fire_nx;
        end
    end

`ifdef IVL_UVM_OVL_XCHECK_EN
    // Pulse fire_xz for any enabled sample containing X/Z.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fire_xz <= 1'b0;
        end else begin
            fire_xz <= enable & (|xz_vec);
        end
    end
`else
    assign fire_xz = 1'b0;
`endif

    logic [CH_W-1:0]  win_chan;
    logic [WIDTH-1:0] win_value;

    // Pick the lowest-index channel firing this edge; scan high to low so the
    // last assignment is the lowest index.
    always_comb begin
        win_chan  = '0;
        win_value = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (fire_nx[i]) begin
                win_chan  = CH_W'(i);
                win_value = test_expr[i*WIDTH +: WIDTH];
            end
        end
    end

    // First-failure capture: loads once, holds until clear or reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            first_valid <= 1'b0;
            first_chan  <= '0;
            first_value <= '0;
        end else if (clear) begin
            first_valid <= 1'b0;
            first_chan  <= '0;
            first_value <= '0;
        end else if (!first_valid && (|fire_nx)) begin
            first_valid <= 1'b1;
            first_chan  <= win_chan;
            first_value <= win_value;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ivl_uvm_ovl_one_hot_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ivl_uvm_ovl_one_hot_mc
// Purpose  : Scoreboard bench for two checker instances sharing one stimulus:
//            dut0 MODE 0 / threshold 1 / 3-bit counters,
//            dut1 MODE 1 / threshold 3 / 2-bit counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ivl_uvm_ovl_one_hot_mc;

    localparam logic [15:0] P = 16'h1111;   // every channel exactly one-hot

    logic        clock     = 1'b0;
    logic        reset     = 1'b0;
    logic        enable    = 1'b0;
    logic        clear     = 1'b0;
    logic [15:0] test_expr = '0;

    logic [3:0]  fire0, fire1;
    logic        fire_xz0, fire_xz1;
    logic [11:0] cnt0;
    logic [7:0]  cnt1;
    logic        fv0, fv1;
    logic [1:0]  fc0, fc1;
    logic [3:0]  fval0, fval1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ivl_uvm_ovl_one_hot_mc #(
        .WIDTH(4), .CHANNELS(4), .MODE(0), .FIRE_THRESH(1), .CNT_W(3)
    ) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .test_expr(test_expr), .fire(fire0), .fire_xz(fire_xz0),
        .fire_count(cnt0), .first_valid(fv0), .first_chan(fc0),
        .first_value(fval0)
    );

    ivl_uvm_ovl_one_hot_mc #(
        .WIDTH(4), .CHANNELS(4), .MODE(1), .FIRE_THRESH(3), .CNT_W(2)
    ) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .test_expr(test_expr), .fire(fire1), .fire_xz(fire_xz1),
        .fire_count(cnt1), .first_valid(fv1), .first_chan(fc1),
        .first_value(fval1)
    );

    typedef struct {
        logic [3:0]  fire0;
        logic [11:0] cnt0;
        logic        fv0;
        logic [1:0]  fc0;
        logic [3:0]  fval0;
        logic [3:0]  fire1;
        logic [7:0]  cnt1;
        logic        fv1;
        logic [1:0]  fc1;
        logic [3:0]  fval1;
    } exp_t;

    exp_t q[$];

    // Reference model: run length of consecutive enabled violations per channel.
    int         mode_of [2] = '{0, 1};
    int         thr_of  [2] = '{1, 3};
    int         cmax_of [2] = '{7, 3};
    int         run     [2][4];
    int         cnt     [2][4];
    logic       mfv     [2];
    int         mfc     [2];
    logic [3:0] mfval   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic en, input logic clr,
                              input logic [15:0] expr, output exp_t e);
        logic [3:0] f [2];
        logic [3:0] s;
        bit         v;
        bit         found;
        for (int d = 0; d < 2; d++) f[d] = '0;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 4; c++) begin
                    run[d][c] = 0;
                    cnt[d][c] = 0;
                end
                mfv[d] = 1'b0; mfc[d] = 0; mfval[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 4; c++) begin
                    s = expr[c*4 +: 4];
                    v = (mode_of[d] == 0) ? ($countones(s) != 1) : ($countones(s) > 1);
                    if (en && v) begin
                        if (run[d][c] < 1000) run[d][c]++;
                        if (run[d][c] == thr_of[d]) f[d][c] = 1'b1;
                    end else begin
                        run[d][c] = 0;
                    end
                    if (clr) cnt[d][c] = 0;
                    else if (f[d][c] && cnt[d][c] < cmax_of[d]) cnt[d][c]++;
                end
                if (clr) begin
                    mfv[d] = 1'b0; mfc[d] = 0; mfval[d] = '0;
                end else if (!mfv[d] && f[d] != 4'd0) begin
                    found = 0;
                    for (int c = 0; c < 4; c++) begin
                        if (f[d][c] && !found) begin
                            found    = 1;
                            mfv[d]   = 1'b1;
                            mfc[d]   = c;
                            mfval[d] = expr[c*4 +: 4];
                        end
                    end
                end
            end
        end
        e.fire0 = f[0];
        e.fire1 = f[1];
        for (int c = 0; c < 4; c++) begin
            e.cnt0[c*3 +: 3] = 3'(cnt[0][c]);
            e.cnt1[c*2 +: 2] = 2'(cnt[1][c]);
        end
        e.fv0 = mfv[0]; e.fc0 = 2'(mfc[0]); e.fval0 = mfval[0];
        e.fv1 = mfv[1]; e.fc1 = 2'(mfc[1]); e.fval1 = mfval[1];
    endtask

    // Drive one sample at the falling edge and queue its expected response.
    task automatic step(input logic rst, input logic en, input logic clr, input logic [15:0] expr);
        exp_t e;
        @(negedge clock);
        reset     = rst;
        enable    = en;
        clear     = clr;
        test_expr = expr;
        model_step(rst, en, clr, expr, e);
        q.push_back(e);
    endtask

    // Monitor: after every rising edge compare outputs with the oldest expectation.
    always begin : mon
        exp_t e;
        @(posedge clock);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("fire0",       32'(fire0),    32'(e.fire0));
            chk("fire_count0", 32'(cnt0),     32'(e.cnt0));
            chk("first_valid0",32'(fv0),      32'(e.fv0));
            chk("first_chan0", 32'(fc0),      32'(e.fc0));
            chk("first_value0",32'(fval0),    32'(e.fval0));
            chk("fire_xz0",    32'(fire_xz0), 32'd0);
            chk("fire1",       32'(fire1),    32'(e.fire1));
            chk("fire_count1", 32'(cnt1),     32'(e.cnt1));
            chk("first_valid1",32'(fv1),      32'(e.fv1));
            chk("first_chan1", 32'(fc1),      32'(e.fc1));
            chk("first_value1",32'(fval1),    32'(e.fval1));
            chk("fire_xz1",    32'(fire_xz1), 32'd0);
        end
    end

    function automatic logic [3:0] rand_slice();
        logic [3:0] s;
        if ($urandom_range(0, 3) < 2) s = 4'(1 << $urandom_range(0, 3));
        else                          s = 4'($urandom_range(0, 15));
        return s;
    endfunction

    initial begin
        logic [15:0] r;
        // Reset held for two clocks, then all-zero input with enable high.
        repeat (2) step(1'b0, 1'b1, 1'b0, 16'h0000);
        repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0000);
        // Zero-one-hot sequence on channel 0.
        step(1'b1, 1'b1, 1'b0, 16'h1110);
        step(1'b1, 1'b1, 1'b0, 16'h1114);
        repeat (3) step(1'b1, 1'b1, 1'b0, 16'h111C);
        step(1'b1, 1'b1, 1'b0, 16'h1117);
        repeat (2) step(1'b1, 1'b1, 1'b0, P);
        step(1'b1, 1'b1, 1'b1, P);
        // Channels 1 and 2 violate together, then channel 3 alone, then clear.
        repeat (3) step(1'b1, 1'b1, 1'b0, 16'h1331);
        repeat (2) step(1'b1, 1'b1, 1'b0, P);
        repeat (3) step(1'b1, 1'b1, 1'b0, 16'h3111);
        step(1'b1, 1'b1, 1'b0, P);
        step(1'b1, 1'b1, 1'b1, P);
        step(1'b1, 1'b1, 1'b0, P);
        // Clear in the same cycle as a fire.
        step(1'b1, 1'b1, 1'b1, 16'h1110);
        step(1'b1, 1'b1, 1'b0, P);
        // Threshold-3 pattern V,V,P,V,V,V,V on channel 0.
        repeat (2) step(1'b1, 1'b1, 1'b0, 16'h1113);
        step(1'b1, 1'b1, 1'b0, P);
        repeat (4) step(1'b1, 1'b1, 1'b0, 16'h1113);
        step(1'b1, 1'b1, 1'b0, P);
        // Enable drop breaks a streak.
        repeat (2) step(1'b1, 1'b1, 1'b0, 16'h1113);
        step(1'b1, 1'b0, 1'b0, 16'h1113);
        repeat (3) step(1'b1, 1'b1, 1'b0, 16'h1113);
        step(1'b1, 1'b1, 1'b0, P);
        // Five separate runs drive the counters into saturation.
        repeat (5) begin
            repeat (3) step(1'b1, 1'b1, 1'b0, 16'h1113);
            step(1'b1, 1'b1, 1'b0, P);
        end
        // Asynchronous reset in the middle of a streak.
        repeat (2) step(1'b1, 1'b1, 1'b0, 16'h1110);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("async_fire0",  32'(fire0), 32'd0);
        chk("async_cnt0",   32'(cnt0),  32'd0);
        chk("async_fv0",    32'(fv0),   32'd0);
        chk("async_fire1",  32'(fire1), 32'd0);
        chk("async_cnt1",   32'(cnt1),  32'd0);
        chk("async_fv1",    32'(fv1),   32'd0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 16'h1113);
        repeat (2) step(1'b1, 1'b1, 1'b0, P);
        // Randomized traffic; inputs are often held to build longer runs.
        r = P;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                for (int c = 0; c < 4; c++) r[c*4 +: 4] = rand_slice();
            end
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 31) == 0), r);
        end
        repeat (3) @(posedge clock);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ivl_uvm_ovl_one_hot_mc.md
# ivl_uvm_ovl_one_hot_mc

Multi-channel, parametrised one-hot / zero-one-hot assertion checker for the OVL-style checker library used by the ivl_uvm benches. Each of CHANNELS independent slices of test_expr is checked every clock. A channel fires only after FIRE_THRESH consecutive violating samples. Per-channel saturating violation counters and a first-failure capture register let benches check results without parsing simulator messages.

## Interface
- WIDTH, 4, bits per channel (≥2)
- CHANNELS, 1, number of independent channels (≥1)
- MODE, 0, 0 = exactly one bit set; 1 = zero or one bit set
- FIRE_THRESH, 1, consecutive violating samples needed to fire (1..255)
- CNT_W, 8, width of each per-channel violation counter
- CH_W, derived = max(1, $clog2(CHANNELS)), width of first_chan

- clock  in  1  sampling clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  check enable; low = samples ignored, streaks cleared
- clear  in  1  synchronous clear of counters and first-fail capture
- test_expr  in  CHANNELS*WIDTH  channel c = bits [c*WIDTH +: WIDTH]
- fire  out  CHANNELS  one-cycle pulse per channel on threshold crossing
- fire_xz  out  1  one-cycle pulse when any enabled channel samples X/Z
- fire_count  out  CHANNELS*CNT_W  per-channel saturating fire count, channel c = [c*CNT_W +: CNT_W]
- first_valid  out  1  first-failure capture holds data
- first_chan  out  CH_W  lowest channel index that fired first
- first_value  out  WIDTH  test_expr slice of that channel at the firing sample

## Operation
- Violation: MODE 0 → popcount != 1; MODE 1 → popcount > 1.
- Per-channel FSM, clocked by clock:
  - IDLE: enable low. Streak = 0. Go to ARMED when enable is high.
  - ARMED: on a violation, streak = 1. If FIRE_THRESH == 1, go to FIRED, else go to STREAK.
  - STREAK: a violation increments streak. When streak reaches FIRE_THRESH, go to FIRED. A passing sample goes to ARMED with streak = 0.
  - FIRED: fire pulses on entry only. Later violations hold FIRED with no new pulse. A passing sample goes to ARMED. This gives one fire per violation run.
  - Any state goes to IDLE when enable is low, with no pulse.
- fire_count[c] increments on each fire[c] pulse and saturates at 2^CNT_W−1.
- First-failure capture:
  - Loads on the first fire pulse while first_valid = 0.
  - If several channels fire in the same cycle, the lowest index wins.
  - Holds until clear or reset.
- clear:
  - Zeroes all fire_count values, first_valid, first_chan and first_value.
  - Does not affect FSM state or streaks.
  - If clear and a fire occur in the same cycle, clear wins. The fire pulse still appears on fire.

## Timing
- Sample taken at rising clock edge N. fire and fire_xz are registered and high during cycle N+1.
- fire_count and first_* update at the same edge as the fire pulse.
- Fire latency from the first violating sample: FIRE_THRESH cycles.
- Reset values: fire = 0, fire_xz = 0, fire_count = 0, first_valid = 0, first_chan = 0, first_value = 0. All FSMs are in IDLE.
- Reset asserted mid-streak clears immediately, without waiting for a clock edge.
- After reset deasserts, the first sample is evaluated at the first rising edge with enable high. That sample transitions IDLE→ARMED and is also checked.

## Configuration
- Macro: IVL_UVM_OVL_XCHECK_EN.
- When defined:
  - Any X/Z bit in an enabled channel's slice pulses fire_xz in the next cycle.
  - That sample is treated as a violation for streak and fire purposes.
  - first_value captures the raw 4-state slice.
- When undefined:
  - No X/Z detection logic is built and fire_xz is tied to 0.
  - Behaviour for X/Z inputs is unspecified.

## Test plan
- Default parameters, reset low for 2 clocks then high, test_expr = 4'b0000, enable = 1 → fire = 1 in the cycle after the first sampled edge; fire_count = 1, first_valid = 1, first_chan = 0, first_value = 4'b0000.
- MODE = 1, test_expr sequence 4'b0000, 4'b0100, 4'b1100 (held 3 clocks), 4'b0111 → exactly one fire pulse, for the 4'b1100 run. 4'b0111 produces no new pulse because there was no passing sample in between. fire_count = 1.
- FIRE_THRESH = 3, violation pattern V,V,P,V,V,V,V → one fire pulse, 3 cycles after the 4th sample. The first 2-long run does not fire.
- CHANNELS = 4, channels 2 and 1 both violate at the same edge → fire = 4'b0110, first_chan = 1. A later fire on channel 3 leaves first_* unchanged. clear then zeroes fire_count and first_valid.
- CNT_W = 2, 5 separate violation runs → fire_count = 3 (saturated). Reset asserted while a streak is in progress → all outputs return to 0 without waiting for a clock edge.
- With IVL_UVM_OVL_XCHECK_EN, test_expr = 4'b0x01 → fire_xz and fire both pulse. Rebuilt without the macro → fire_xz stays 0 throughout.
